aud_frame_fifo: RTL and testbench

AUD_FRAME_FIFO -- requirements
Module: aud_frame_fifo

---
 rtl/g729_pkg.sv | 25 ++
 rtl/aud_fifo_ram.sv | 35 +++
 rtl/aud_frame_fifo.sv | 155 +++++++++++++++
 tb/tb_aud_frame_fifo.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/g729_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : g729_pkg
// Description : Shared constants and write-side FSM encoding for the G729
//               audio frame FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package g729_pkg;

  // Samples per G729 frame: 10 ms at 8 kHz.
  localparam int FRAME_LEN_DEF = 80;

  // Width of one incoming PCM sample.
  localparam int SAMPLE_WIDTH = 16;

  // One-hot write-side state encoding.
  typedef enum logic [2:0] {
    ST_FILL  = 3'b001,
    ST_STALL = 3'b010,
    ST_FLUSH = 3'b100
  } wr_state_e;

endpackage : g729_pkg
`default_nettype wire

// File: rtl/aud_fifo_ram.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : aud_fifo_ram
// Description : FIFO storage, one synchronous write port and one
//               asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module aud_fifo_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: store the word on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : aud_fifo_ram
`default_nettype wire

// File: rtl/aud_frame_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : aud_frame_fifo
// Description : First-word-fall-through sample FIFO in front of the G729
//               LSP stage. Sign-extends 16-bit PCM, counts frames of
//               FRAME_LEN accepted samples, keeps sticky over/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module aud_frame_fifo
  import g729_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 10,
  parameter int RAM_DATA_WIDTH = 32,
  parameter int FRAME_LEN      = FRAME_LEN_DEF
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      sys_ce,
  input  logic                      smp_flush,
  input  logic                      smp_valid,
  input  logic [SAMPLE_WIDTH-1:0]   smp_data,
  output logic                      smp_ready,
  input  logic                      lsp_read_en,
  output logic [RAM_DATA_WIDTH-1:0] aff_read_data,
  output logic [RAM_ADDR_WIDTH-1:0] aff_data_count,
  output logic                      aff_data_full,
  output logic                      aff_data_empty,
  output logic                      aff_frame_done,
  output logic                      aff_overflow,
  output logic                      aff_underflow
);

  localparam int FCNT_WIDTH = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [RAM_ADDR_WIDTH-1:0] COUNT_MAX  = '1;
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_ONE   = RAM_ADDR_WIDTH'(1);
  localparam logic [FCNT_WIDTH-1:0]     FRAME_LAST = FCNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [FCNT_WIDTH-1:0]     FCNT_ONE   = FCNT_WIDTH'(1);

  wr_state_e                 state;
  logic [RAM_ADDR_WIDTH-1:0] wr_ptr;
  logic [RAM_ADDR_WIDTH-1:0] rd_ptr;
  logic [RAM_ADDR_WIDTH-1:0] count_next;
  logic [FCNT_WIDTH-1:0]     frame_cnt;
  logic [RAM_DATA_WIDTH-1:0] wr_word;
  logic [RAM_DATA_WIDTH-1:0] ram_rd_data;
  logic                      flush;
  logic                      push;
  logic                      pop;
  logic                      ovf_set;
  logic                      udf_set;

  // Everything, including flush, is frozen while the clock enable is low.
  assign flush = sys_ce & smp_flush;

  // Ready depends only on registered full state, so a same-cycle pop never
  // rescues a sample offered while full. Held low while in reset.
  assign smp_ready = sys_rst_n & ~smp_flush & ~aff_data_full & (state != ST_STALL);

  assign push    = sys_ce & smp_valid & smp_ready;
  assign pop     = sys_ce & lsp_read_en & ~smp_flush & ~aff_data_empty;
  assign ovf_set = sys_ce & smp_valid & ~smp_flush & aff_data_full;
  assign udf_set = sys_ce & lsp_read_en & ~smp_flush & aff_data_empty;

  assign wr_word = {{(RAM_DATA_WIDTH - SAMPLE_WIDTH){smp_data[SAMPLE_WIDTH-1]}}, smp_data};

  // Head word falls through; force zero when nothing valid is stored.
  assign aff_read_data = aff_data_empty ? '0 : ram_rd_data;

  aud_fifo_ram #(
    .ADDR_WIDTH (RAM_ADDR_WIDTH),
    .DATA_WIDTH (RAM_DATA_WIDTH)
  ) u_ram (
    .clk     (sys_clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  // Next occupancy: push and pop together leave it unchanged.
  always_comb begin
    count_next = aff_data_count;
    if (push && !pop) begin
      count_next = aff_data_count + ADDR_ONE;
    end else if (pop && !push) begin
      count_next = aff_data_count - ADDR_ONE;
    end
  end

  // Pointers, count and the full/empty flags derived from the next count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      aff_data_count <= '0;
      aff_data_full  <= 1'b0;
      aff_data_empty <= 1'b1;
    end else if (flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      aff_data_count <= '0;
      aff_data_full  <= 1'b0;
      aff_data_empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_ONE;
      if (pop)  rd_ptr <= rd_ptr + ADDR_ONE;
      aff_data_count <= count_next;
      aff_data_full  <= (count_next == COUNT_MAX);
      aff_data_empty <= (count_next == '0);
    end
  end

  // Frame counter, one-cycle frame pulse and sticky error flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt      <= '0;
      aff_frame_done <= 1'b0;
      aff_overflow   <= 1'b0;
      aff_underflow  <= 1'b0;
    end else if (flush) begin
      frame_cnt      <= '0;
      aff_frame_done <= 1'b0;
      aff_overflow   <= 1'b0;
      aff_underflow  <= 1'b0;
    end else begin
      // The pulse follows a push only, so it never stretches past one cycle.
      aff_frame_done <= push && (frame_cnt == FRAME_LAST);
      if (push) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + FCNT_ONE;
      end
      if (ovf_set) aff_overflow  <= 1'b1;
      if (udf_set) aff_underflow <= 1'b1;
    end
  end

  // Write-side state: stall while full, one flush cycle, otherwise fill.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_FILL;
    end else if (flush) begin
      state <= ST_FLUSH;
    end else begin
      case (state)
        ST_FILL:  if (count_next == COUNT_MAX) state <= ST_STALL;
        ST_STALL: if (pop) state <= ST_FILL;
        ST_FLUSH: state <= ST_FILL;
        default:  state <= ST_FILL;
      endcase
    end
  end

endmodule : aud_frame_fifo
`default_nettype wire

// File: tb/tb_aud_frame_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_aud_frame_fifo
// Description : Directed self-checking bench for aud_frame_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_frame_fifo;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        flush;
  logic        valid;
  logic [15:0] data;
  logic        ready;
  logic        rd_en;
  logic [31:0] rdata;
  logic [9:0]  count;
  logic        full;
  logic        empty;
  logic        done;
  logic        ovf;
  logic        udf;

  int n_checks = 0;
  int n_fail   = 0;

  aud_frame_fifo #(
    .RAM_ADDR_WIDTH (10),
    .RAM_DATA_WIDTH (32),
    .FRAME_LEN      (80)
  ) dut (
    .sys_clk        (clk),
    .sys_rst_n      (rst_n),
    .sys_ce         (ce),
    .smp_flush      (flush),
    .smp_valid      (valid),
    .smp_data       (data),
    .smp_ready      (ready),
    .lsp_read_en    (rd_en),
    .aff_read_data  (rdata),
    .aff_data_count (count),
    .aff_data_full  (full),
    .aff_data_empty (empty),
    .aff_frame_done (done),
    .aff_overflow   (ovf),
    .aff_underflow  (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    valid = 1'b1;
    data  = d;
    step();
    valid = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  // 80 consecutive pushes: no pulse before the last one, a pulse right after it.
  task automatic push_frame(input string tag);
    int early;
    early = 0;
    valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      data = 16'(i + 100);
      step();
      if (i < 79) early += int'(done);
    end
    valid = 1'b0;
    check({tag, "_early_pulses"}, early, 0);
    check({tag, "_done"}, {31'd0, done}, 1);
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    ce    = 1'b1;
    flush = 1'b0;
    valid = 1'b0;
    data  = '0;
    rd_en = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst_ready", {31'd0, ready}, 0);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_full",  {31'd0, full},  0);
    check("rst_count", {22'd0, count}, 0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_done",  {31'd0, done},  0);
    check("rst_ovf",   {31'd0, ovf},   0);
    check("rst_udf",   {31'd0, udf},   0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", {31'd0, ready}, 1);

    // Three samples, sign extension and FWFT order
    push(16'h0001);
    check("fwft_head", rdata, 32'h0000_0001);
    push(16'hFFFF);
    push(16'h7FFF);
    check("three_count", {22'd0, count}, 3);
    check("three_empty", {31'd0, empty}, 0);
    check("pop1_data", rdata, 32'h0000_0001);
    pop();
    check("pop2_data", rdata, 32'hFFFF_FFFF);
    pop();
    check("pop3_data", rdata, 32'h0000_7FFF);
    pop();
    check("drained_empty", {31'd0, empty}, 1);
    check("drained_count", {22'd0, count}, 0);
    check("drained_rdata", rdata, 32'h0);
    check("drained_udf",   {31'd0, udf},   0);

    // Clock enable low freezes everything
    ce    = 1'b0;
    valid = 1'b1;
    data  = 16'h1234;
    step();
    ce    = 1'b1;
    valid = 1'b0;
    check("ce_low_count", {22'd0, count}, 0);
    check("ce_low_empty", {31'd0, empty}, 1);

    // 160 pushes -> pulses after the 80th and 160th
    flush = 1'b1;
    step();
    flush  = 1'b0;
    pulses = 0;
    valid  = 1'b1;
    for (int i = 0; i < 160; i++) begin
      data = 16'(i);
      step();
      pulses += int'(done);
      if (i == 79)  check("frame_done_80",  {31'd0, done}, 1);
      if (i == 159) check("frame_done_160", {31'd0, done}, 1);
    end
    valid = 1'b0;
    step();
    check("frame_pulse_total", pulses, 2);
    check("frame_done_clear", {31'd0, done}, 0);
    check("count_160", {22'd0, count}, 160);

    // Fill to 1023
    valid = 1'b1;
    for (int i = 160; i < 1023; i++) begin
      data = 16'(i);
      step();
    end
    valid = 1'b0;
    check("full_count", {22'd0, count}, 1023);
    check("full_flag",  {31'd0, full},  1);
    check("full_ready", {31'd0, ready}, 0);
    check("full_ovf_pre", {31'd0, ovf}, 0);
    push(16'hABCD);
    check("ovf_set",   {31'd0, ovf},   1);
    check("ovf_count", {22'd0, count}, 1023);
    // Push offered together with a pop while full is still dropped
    valid = 1'b1;
    rd_en = 1'b1;
    data  = 16'h5555;
    step();
    valid = 1'b0;
    rd_en = 1'b0;
    check("pop_full_count", {22'd0, count}, 1022);
    check("pop_full_flag",  {31'd0, full},  0);
    check("pop_full_ready", {31'd0, ready}, 1);
    check("ovf_sticky",     {31'd0, ovf},   1);

    // Flush with push and pop pending
    flush = 1'b1;
    valid = 1'b1;
    rd_en = 1'b1;
    step();
    flush = 1'b0;
    valid = 1'b0;
    rd_en = 1'b0;
    check("flush_count", {22'd0, count}, 0);
    check("flush_empty", {31'd0, empty}, 1);
    check("flush_ovf",   {31'd0, ovf},   0);
    check("flush_rdata", rdata, 32'h0);

    // Pop on empty with a simultaneous push
    valid = 1'b1;
    rd_en = 1'b1;
    data  = 16'h8000;
    step();
    valid = 1'b0;
    rd_en = 1'b0;
    check("udf_set",   {31'd0, udf},   1);
    check("udf_count", {22'd0, count}, 1);
    check("udf_head",  rdata, 32'hFFFF_8000);

    // 500 deep, then 600 cycles of push+pop across the pointer wrap
    flush = 1'b1;
    step();
    flush = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      data = 16'(i);
      step();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      data = 16'(500 + i);
      check("wrap_order", rdata, 32'(i));
      step();
    end
    valid = 1'b0;
    rd_en = 1'b0;
    check("wrap_count", {22'd0, count}, 500);
    check("wrap_head",  rdata, 32'd600);

    // Flush at count 200 clears flags and frame counter
    flush = 1'b1;
    step();
    flush = 1'b0;
    pop();
    check("udf_again", {31'd0, udf}, 1);
    valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      data = 16'(i);
      step();
    end
    valid = 1'b0;
    check("count_200", {22'd0, count}, 200);
    flush = 1'b1;
    valid = 1'b1;
    rd_en = 1'b1;
    step();
    flush = 1'b0;
    valid = 1'b0;
    rd_en = 1'b0;
    check("flush200_count", {22'd0, count}, 0);
    check("flush200_empty", {31'd0, empty}, 1);
    check("flush200_udf",   {31'd0, udf},   0);
    push_frame("flush200_frame");

    // Asynchronous reset in the middle of a frame
    valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      data = 16'(i);
      step();
    end
    valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", {22'd0, count}, 0);
    check("midrst_empty", {31'd0, empty}, 1);
    check("midrst_ready", {31'd0, ready}, 0);
    step();
    rst_n = 1'b1;
    step();
    check("midrst_rdata", rdata, 32'h0);
    push_frame("midrst_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_aud_frame_fifo
`default_nettype wire
